// File: rtl/alarm_ctrl.sv
// Alarm sequencer: matches the seconds-of-day timestamp against a stored alarm
// time and sequences ringing, timed auto-off, bounded snooze and dismiss.
module alarm_ctrl #(
  parameter int unsigned COUNTER_MAX = 86399,
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 540,
  parameter int unsigned MAX_SNOOZES = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sec_tick,
  input  logic [16:0] counter_state,
  input  logic        set_flag,
  input  logic        alarm_flag,
  input  logic [16:0] alarm_time,
  input  logic        alarm_enable,
  input  logic        snooze,
  input  logic        dismiss,
  output logic        alarm_state,
  output logic        armed,
  output logic [1:0]  snooze_count,
  output logic [16:0] alarm_time_q
);

  localparam int unsigned RW = $clog2(RING_SECS + 1);
  localparam int unsigned SW = $clog2(SNOOZE_SECS + 1);
  localparam logic [RW-1:0] RING_LOAD    = RW'(RING_SECS);
  localparam logic [SW-1:0] SNOOZE_LOAD  = SW'(SNOOZE_SECS);
  localparam logic [16:0]   TIME_MAX     = 17'(COUNTER_MAX);
  localparam logic [1:0]    SNOOZE_LIMIT = 2'(MAX_SNOOZES);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZED  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [RW-1:0] r_ringTimer;
  logic [RW-1:0] w_nextRingTimer;
  logic [SW-1:0] r_snoozeTimer;
  logic [SW-1:0] w_nextSnoozeTimer;
  logic [1:0]    r_snoozeCount;
  logic [1:0]    w_nextSnoozeCount;
  logic [16:0]   r_alarmTime;
  logic [16:0]   w_nextAlarmTime;
  logic          r_alarmState;
  logic          r_armed;
  logic          w_loadValid;
  logic          w_match;

  assign w_loadValid = alarm_flag && (alarm_time <= TIME_MAX);
  assign w_match     = sec_tick && !set_flag && (counter_state == r_alarmTime);

  // Branch order encodes same-cycle priority: disable, load, dismiss, snooze, expiry, match.
  always_comb begin
    w_nextState       = r_state;
    w_nextRingTimer   = r_ringTimer;
    w_nextSnoozeTimer = r_snoozeTimer;
    w_nextSnoozeCount = r_snoozeCount;
    w_nextAlarmTime   = r_alarmTime;

    if (!alarm_enable) begin
      w_nextState       = DISARMED;
      w_nextRingTimer   = '0;
      w_nextSnoozeTimer = '0;
      w_nextSnoozeCount = '0;
    end else if (w_loadValid) begin
      w_nextAlarmTime   = alarm_time;
      w_nextState       = ARMED;
      w_nextRingTimer   = '0;
      w_nextSnoozeTimer = '0;
      w_nextSnoozeCount = '0;
    end else begin
      unique case (r_state)
        DISARMED: w_nextState = ARMED;
        ARMED: begin
          if (w_match) begin
            w_nextState     = RINGING;
            w_nextRingTimer = RING_LOAD;
          end
        end
        RINGING: begin
          if (dismiss) begin
            w_nextState       = ARMED;
            w_nextRingTimer   = '0;
            w_nextSnoozeCount = '0;
          end else if (snooze && (r_snoozeCount < SNOOZE_LIMIT)) begin
            w_nextState       = SNOOZED;
            w_nextRingTimer   = '0;
            w_nextSnoozeTimer = SNOOZE_LOAD;
            w_nextSnoozeCount = r_snoozeCount + 2'd1;
          end else if (sec_tick) begin
            if (r_ringTimer <= RW'(1)) begin
              w_nextState       = ARMED;
              w_nextRingTimer   = '0;
              w_nextSnoozeCount = '0;
            end else begin
              w_nextRingTimer = r_ringTimer - RW'(1);
            end
          end
        end
        SNOOZED: begin
          if (dismiss) begin
            w_nextState       = ARMED;
            w_nextSnoozeTimer = '0;
            w_nextSnoozeCount = '0;
          end else if (sec_tick) begin
            if (r_snoozeTimer <= SW'(1)) begin
              w_nextState       = RINGING;
              w_nextSnoozeTimer = '0;
              w_nextRingTimer   = RING_LOAD;
            end else begin
              w_nextSnoozeTimer = r_snoozeTimer - SW'(1);
            end
          end
        end
        default: w_nextState = DISARMED;
      endcase
    end
  end

  // Output flags are decoded from the next state so they change with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= DISARMED;
      r_ringTimer   <= '0;
      r_snoozeTimer <= '0;
      r_snoozeCount <= '0;
      r_alarmTime   <= '0;
      r_alarmState  <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_ringTimer   <= w_nextRingTimer;
      r_snoozeTimer <= w_nextSnoozeTimer;
      r_snoozeCount <= w_nextSnoozeCount;
      r_alarmTime   <= w_nextAlarmTime;
      r_alarmState  <= (w_nextState == RINGING);
      r_armed       <= (w_nextState != DISARMED);
    end
  end

  assign alarm_state  = r_alarmState;
  assign armed        = r_armed;
  assign snooze_count = r_snoozeCount;
  assign alarm_time_q = r_alarmTime;

endmodule
